// File: rtl/key_debounce_array.sv
// N-key push-button debouncer: 2-FF sync, shared tick prescaler, per-key FSM lanes
// producing level/press/release/long/repeat strobes, plus a registered key-code encoder.

module key_debounce_lane #(
  parameter int ACTIVE_LOW     = 1,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_in,
  output logic level,
  output logic press,
  output logic rls,
  output logic lng,
  output logic rpt
);
  localparam int DW    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HMAX  = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW    = $clog2(HMAX + 1);
  localparam int REP_T = (REPEAT_TICKS == 0) ? 1 : REPEAT_TICKS;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_T - 1);
  localparam logic          REL_LVL   = (ACTIVE_LOW != 0);
  localparam logic          REP_EN    = (REPEAT_TICKS != 0);

  typedef enum logic [2:0] {RELEASED, PRESS_PEND, PRESSED, LONG_HELD, REL_PEND} state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            raw;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            long_flag;
  logic            long_hit, rep_hit;
  logic [HW-1:0]   hold_nxt_p, hold_nxt_l;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {2{REL_LVL}};
    else        sync <= {sync[0], key_in};

  assign raw = sync[1] ^ REL_LVL;

  // Next hold count for a held tick in PRESSED / LONG_HELD; shared with the REL_PEND bounce-back
  // so a short release glitch only costs the ticks actually spent released.
  always_comb begin
    long_hit   = (hold_cnt == LONG_LAST);
    rep_hit    = REP_EN && (hold_cnt == REP_LAST);
    hold_nxt_p = long_hit ? '0 : hold_cnt + HW'(1);
    hold_nxt_l = !REP_EN ? hold_cnt : (rep_hit ? '0 : hold_cnt + HW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RELEASED;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      long_flag <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rls       <= 1'b0;
      lng       <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      press <= 1'b0;
      rls   <= 1'b0;
      lng   <= 1'b0;
      rpt   <= 1'b0;
      if (tick) begin
        case (state)
          RELEASED:
            if (raw) begin
              if (DEBOUNCE_TICKS == 1) begin
                state    <= PRESSED;
                level    <= 1'b1;
                press    <= 1'b1;
                hold_cnt <= '0;
              end else begin
                state  <= PRESS_PEND;
                db_cnt <= DW'(1);
              end
            end
          PRESS_PEND:
            if (!raw) begin
              state  <= RELEASED;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state    <= PRESSED;
              level    <= 1'b1;
              press    <= 1'b1;
              hold_cnt <= '0;
              db_cnt   <= '0;
            end else begin
              db_cnt <= db_cnt + DW'(1);
            end
          PRESSED:
            if (raw) begin
              hold_cnt <= hold_nxt_p;
              if (long_hit) begin
                state <= LONG_HELD;
                lng   <= 1'b1;
              end
            end else if (DEBOUNCE_TICKS == 1) begin
              state <= RELEASED;
              level <= 1'b0;
              rls   <= 1'b1;
            end else begin
              state     <= REL_PEND;
              db_cnt    <= DW'(1);
              long_flag <= 1'b0;
            end
          LONG_HELD:
            if (raw) begin
              hold_cnt <= hold_nxt_l;
              rpt      <= rep_hit;
            end else if (DEBOUNCE_TICKS == 1) begin
              state <= RELEASED;
              level <= 1'b0;
              rls   <= 1'b1;
            end else begin
              state     <= REL_PEND;
              db_cnt    <= DW'(1);
              long_flag <= 1'b1;
            end
          REL_PEND:
            if (raw) begin
              db_cnt <= '0;
              if (long_flag) begin
                state    <= LONG_HELD;
                hold_cnt <= hold_nxt_l;
                rpt      <= rep_hit;
              end else begin
                hold_cnt <= hold_nxt_p;
                state    <= long_hit ? LONG_HELD : PRESSED;
                lng      <= long_hit;
              end
            end else if (db_cnt == DB_LAST) begin
              state  <= RELEASED;
              level  <= 1'b0;
              rls    <= 1'b1;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + DW'(1);
            end
          default: state <= RELEASED;
        endcase
      end
    end
  end
endmodule

module key_debounce_array #(
  parameter int NUM_KEYS       = 4,
  parameter int ACTIVE_LOW     = 1,
  parameter int TICK_CYCLES    = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter int CODE_W         = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic [CODE_W-1:0] enc_code;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lane
    key_debounce_lane #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .key_in(key_in[k]),
      .level (key_level[k]),
      .press (key_press[k]),
      .rls   (key_release[k]),
      .lng   (key_long[k]),
      .rpt   (key_repeat[k])
    );
  end

  // Descending scan so the lowest pressed index wins.
  always_comb begin
    enc_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (key_press[i]) enc_code = CODE_W'(i + 1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= |key_press;
      if (|key_press) key_code <= enc_code;
    end
endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array with a 4-clk tick, 3-tick debounce, 10/5-tick long/repeat.
// Stimulus is phased so the first deciding tick lands 3 clks after each drive.

module tb_key_debounce_array;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level, key_press, key_release, key_long, key_repeat;
  logic [2:0] key_code;
  logic       key_valid;
  int cyc;
  int vec = 0;
  int err = 0;

  key_debounce_array #(
    .NUM_KEYS(4), .ACTIVE_LOW(1), .TICK_CYCLES(4), .DEBOUNCE_TICKS(3),
    .LONG_TICKS(10), .REPEAT_TICKS(5), .CODE_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Mirrors the prescaler phase: ticks fall on edges where cyc (before the edge) is 3 mod 4.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic align();
    for (int i = 0; i < 4 && (cyc % 4) != 1; i++) step();
  endtask

  task automatic go_idle();
    key_in = 4'hF;
    repeat (40) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    key_in = 4'hF;
    #2 rst_n = 1'b0;
    repeat (3) step();
    vec++; if ({key_level, key_press, key_release, key_long, key_repeat} !== 20'h0) begin
      err++; $display("FAIL reset_outs got=%h exp=00000", {key_level, key_press, key_release, key_long, key_repeat});
    end
    vec++; if ({key_code, key_valid} !== 4'h0) begin
      err++; $display("FAIL reset_code got=%b exp=0000", {key_code, key_valid});
    end
    rst_n = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      step();
      vec++; if ({key_level, key_press, key_valid} !== 9'h0) begin
        err++; $display("FAIL idle_after_reset s=%0d got=%b exp=0", s, {key_level, key_press, key_valid});
      end
    end
  endtask

  task automatic test_press_single();
    logic [3:0] ep, el;
    align();
    key_in = 4'b1101;
    for (int s = 1; s <= 20; s++) begin
      step();
      ep = (s == 11) ? 4'b0010 : 4'b0000;
      el = (s >= 11) ? 4'b0010 : 4'b0000;
      vec++; if (key_press !== ep) begin err++; $display("FAIL p1_press s=%0d got=%b exp=%b", s, key_press, ep); end
      vec++; if (key_level !== el) begin err++; $display("FAIL p1_level s=%0d got=%b exp=%b", s, key_level, el); end
      vec++; if (key_valid !== (s == 12)) begin err++; $display("FAIL p1_valid s=%0d got=%b exp=%b", s, key_valid, (s == 12)); end
      if (s == 12) begin
        vec++; if (key_code !== 3'd2) begin err++; $display("FAIL p1_code got=%0d exp=2", key_code); end
      end
    end
    align();
    key_in = 4'hF;
    for (int s = 1; s <= 14; s++) begin
      step();
      ep = (s == 11) ? 4'b0010 : 4'b0000;
      el = (s < 11) ? 4'b0010 : 4'b0000;
      vec++; if (key_release !== ep) begin err++; $display("FAIL p1_release s=%0d got=%b exp=%b", s, key_release, ep); end
      vec++; if (key_level !== el) begin err++; $display("FAIL p1_rel_level s=%0d got=%b exp=%b", s, key_level, el); end
      vec++; if (key_valid !== 1'b0) begin err++; $display("FAIL p1_rel_valid s=%0d got=%b exp=0", s, key_valid); end
    end
    vec++; if (key_code !== 3'd2) begin err++; $display("FAIL p1_code_hold got=%0d exp=2", key_code); end
  endtask

  task automatic test_bounce();
    align();
    for (int h = 0; h < 20; h++) begin
      key_in = (h % 2 == 0) ? 4'b1110 : 4'b1111;
      for (int c = 0; c < 8; c++) begin
        step();
        vec++; if ({key_press[0], key_level[0], key_valid} !== 3'b000) begin
          err++; $display("FAIL bounce h=%0d c=%0d got=%b exp=000", h, c, {key_press[0], key_level[0], key_valid});
        end
      end
    end
    key_in = 4'hF;
    repeat (8) step();
  endtask

  task automatic test_long_repeat();
    logic [3:0] ep, el, elg, erp, erl;
    align();
    key_in = 4'b1011;
    for (int s = 1; s <= 140; s++) begin
      step();
      if (s == 120) key_in = 4'hF;
      ep  = (s == 11) ? 4'b0100 : 4'b0000;
      el  = (s >= 11 && s < 131) ? 4'b0100 : 4'b0000;
      elg = (s == 51) ? 4'b0100 : 4'b0000;
      erp = (s == 71 || s == 91 || s == 111) ? 4'b0100 : 4'b0000;
      erl = (s == 131) ? 4'b0100 : 4'b0000;
      vec++; if (key_press !== ep) begin err++; $display("FAIL lr_press s=%0d got=%b exp=%b", s, key_press, ep); end
      vec++; if (key_level !== el) begin err++; $display("FAIL lr_level s=%0d got=%b exp=%b", s, key_level, el); end
      vec++; if (key_long !== elg) begin err++; $display("FAIL lr_long s=%0d got=%b exp=%b", s, key_long, elg); end
      vec++; if (key_repeat !== erp) begin err++; $display("FAIL lr_repeat s=%0d got=%b exp=%b", s, key_repeat, erp); end
      vec++; if (key_release !== erl) begin err++; $display("FAIL lr_release s=%0d got=%b exp=%b", s, key_release, erl); end
      if (s == 12) begin
        vec++; if ({key_valid, key_code} !== 4'b1011) begin err++; $display("FAIL lr_code got=%b exp=1011", {key_valid, key_code}); end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] ep, el;
    align();
    key_in = 4'b0110;
    for (int s = 1; s <= 16; s++) begin
      step();
      ep = (s == 11) ? 4'b1001 : 4'b0000;
      el = (s >= 11) ? 4'b1001 : 4'b0000;
      vec++; if (key_press !== ep) begin err++; $display("FAIL sim_press s=%0d got=%b exp=%b", s, key_press, ep); end
      vec++; if (key_level !== el) begin err++; $display("FAIL sim_level s=%0d got=%b exp=%b", s, key_level, el); end
      vec++; if (key_valid !== (s == 12)) begin err++; $display("FAIL sim_valid s=%0d got=%b exp=%b", s, key_valid, (s == 12)); end
      if (s == 12) begin
        vec++; if (key_code !== 3'd1) begin err++; $display("FAIL sim_code got=%0d exp=1", key_code); end
      end
    end
    align();
    key_in = 4'hF;
    for (int s = 1; s <= 12; s++) begin
      step();
      ep = (s == 11) ? 4'b1001 : 4'b0000;
      vec++; if (key_release !== ep) begin err++; $display("FAIL sim_release s=%0d got=%b exp=%b", s, key_release, ep); end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] ep, el, elg;
    align();
    key_in = 4'b1101;
    for (int s = 1; s <= 60; s++) begin
      step();
      if (s == 16) key_in = 4'b1111;
      if (s == 20) key_in = 4'b1101;
      ep  = (s == 11) ? 4'b0010 : 4'b0000;
      el  = (s >= 11) ? 4'b0010 : 4'b0000;
      elg = (s == 55) ? 4'b0010 : 4'b0000;
      vec++; if (key_press !== ep) begin err++; $display("FAIL gl_press s=%0d got=%b exp=%b", s, key_press, ep); end
      vec++; if (key_level !== el) begin err++; $display("FAIL gl_level s=%0d got=%b exp=%b", s, key_level, el); end
      vec++; if (key_release !== 4'b0000) begin err++; $display("FAIL gl_release s=%0d got=%b exp=0000", s, key_release); end
      vec++; if (key_long !== elg) begin err++; $display("FAIL gl_long s=%0d got=%b exp=%b", s, key_long, elg); end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [3:0] ep, el;
    align();
    key_in = 4'b0111;
    for (int s = 1; s <= 14; s++) begin
      step();
      el = (s >= 11) ? 4'b1000 : 4'b0000;
      vec++; if (key_level !== el) begin err++; $display("FAIL rm_pre_level s=%0d got=%b exp=%b", s, key_level, el); end
    end
    rst_n = 1'b0;
    #1;
    vec++; if ({key_level, key_press, key_release, key_long, key_repeat, key_code, key_valid} !== 24'h0) begin
      err++; $display("FAIL rm_async_clear got=%h exp=000000",
                      {key_level, key_press, key_release, key_long, key_repeat, key_code, key_valid});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      step();
      ep = (s == 12) ? 4'b1000 : 4'b0000;
      el = (s >= 12) ? 4'b1000 : 4'b0000;
      vec++; if (key_press !== ep) begin err++; $display("FAIL rm_press s=%0d got=%b exp=%b", s, key_press, ep); end
      vec++; if (key_level !== el) begin err++; $display("FAIL rm_level s=%0d got=%b exp=%b", s, key_level, el); end
      vec++; if (key_release !== 4'b0000) begin err++; $display("FAIL rm_release s=%0d got=%b exp=0000", s, key_release); end
      vec++; if (key_valid !== (s == 13)) begin err++; $display("FAIL rm_valid s=%0d got=%b exp=%b", s, key_valid, (s == 13)); end
      if (s == 13) begin
        vec++; if (key_code !== 3'd4) begin err++; $display("FAIL rm_code got=%0d exp=4", key_code); end
      end
    end
    go_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press_single();
    test_bounce();
    test_long_repeat();
    test_simultaneous();
    test_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
